imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that fills the fetch stage's 256-word instruction memory before the core runs. It sits between a byte source (UART receiver or testbench) and the IMEM write port, assembling big-endian 32-bit words and writing them to consecutive word addresses. It holds the core in reset or stall while a load is in progress. It validates each load with an XOR checksum and reports completion or error.

## Interface
Parameters:
- HEADER, 8'hA5, start-of-frame byte.
- TIMEOUT, 1024, maximum idle cycles between bytes inside a frame before abort (≥2).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte; a byte transfers on rx_valid && rx_ready at posedge clk.
- imem_we  output  1  one-cycle IMEM write strobe.
- imem_addr  output  8  word index, equal to PC[9:2] of the fetched word.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  high while a frame is in progress; drives PCWrite low and the core reset high.
- load_done  output  1  sticky: last frame passed its checksum.
- load_error  output  1  sticky: last frame failed its checksum or timed out.

## Operation
- Frame format: HEADER, then COUNT (N words, 8'h00 = 256), then N×4 data bytes (MSB first per word), then CHK = XOR of all data bytes.
  - HEADER, COUNT and CHK are excluded from the XOR.
- States: IDLE, COUNT, DATA, CHECK.
- IDLE:
  - A byte equal to HEADER moves to COUNT.
  - Clears load_done and load_error.
  - Sets cpu_hold.
  - Any other byte is discarded with no state change.
- COUNT:
  - Latches N into a 9-bit remaining-words counter, with 0 mapped to 256.
  - Clears the word index, byte index and XOR accumulator.
  - Moves to DATA.
- DATA:
  - Shifts each byte into a 32-bit assembly register and XORs it into the accumulator.
  - On the 4th byte of a word, the registered write fires next cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word.
  - After the write, the word index increments (8-bit, wraps only after 256) and the remaining count decrements.
  - Moves to CHECK after the 4th byte of the last word.
- CHECK:
  - On the next byte, a match with the accumulator sets load_done; a mismatch sets load_error.
  - Clears cpu_hold and returns to IDLE.
- Timeout:
  - In COUNT, DATA or CHECK, an idle counter resets on every accepted byte.
  - Reaching TIMEOUT cycles without a byte sets load_error, clears cpu_hold and returns to IDLE.
  - No further writes occur; already-written words remain in IMEM.
- A HEADER value arriving in COUNT, DATA or CHECK is treated as data or count, never as a resync.
- rx_ready is high in every state; the loader never back-pressures.

## Timing
- Reset values:
  - rx_ready=0; it is registered and rises on the first clock edge after reset deasserts.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=0, load_done=0, load_error=0.
  - State is IDLE.
- Accepts one byte per cycle at full rate; back-to-back frames are legal (a HEADER is accepted the cycle after CHK).
- Write latency: imem_we asserts exactly 1 cycle after the 4th byte of a word is accepted, for 1 cycle.
  - A byte accepted in that same cycle is processed normally.
- cpu_hold rises 1 cycle after HEADER is accepted and falls 1 cycle after CHK is accepted or the timeout fires.
- load_done and load_error update in the same cycle that cpu_hold falls. They are never both 1.
- Timeout fires on the cycle the idle counter reaches TIMEOUT, i.e. TIMEOUT cycles after the last accepted byte.
- Reset mid-frame: all outputs return to reset values immediately and any partially assembled word is dropped.
- Gaps (rx_valid low) inside a frame shorter than TIMEOUT have no effect on the result.

## Test plan
- Nominal load: bytes A5 02 8C 22 00 04 00 43 20 20 E9 at full rate.
  - Writes addr 0 = 8C220004, then addr 1 = 00432020.
  - load_done=1, load_error=0, cpu_hold low 1 cycle after E9.
- Bad checksum: same frame with CHK=E8.
  - Both words are still written.
  - load_error=1, load_done=0.
- COUNT=00: 1024 data bytes of 00 with CHK=00.
  - 256 writes, addresses 0..255 in order, no wrap to 0.
  - load_done=1.
- Timeout: A5 01 8C 22, then rx_valid held low for TIMEOUT cycles.
  - No imem_we.
  - load_error=1 at exactly TIMEOUT cycles after byte 22; cpu_hold falls.
- Garbage and gaps: bytes 00 FF 12 in IDLE are ignored. Then A5 01 DE AD BE EF 22 is sent with 5-cycle gaps between bytes.
  - Single write addr 0 = DEADBEEF.
  - load_done=1.
- Reset mid-frame: reset asserted after A5 01 DE AD.
  - All outputs return to reset values immediately, no write occurs.
  - A following complete frame loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from a framed byte
// stream, writes them to the 256-word IMEM and validates the frame with an XOR checksum.
module imem_loader #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK} state_t;

  state_t            state_q, state_d;
  logic              rx_ready_d, imem_we_d, cpu_hold_d, load_done_d, load_error_d;
  logic [7:0]        imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        acc_q, acc_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              rx_fire_c;

  assign rx_fire_c = rx_valid && rx_ready;

  // State and all registered outputs/datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= 8'd0;
      imem_wdata  <= 32'd0;
      cpu_hold    <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      remaining_q <= 9'd0;
      word_idx_q  <= 8'd0;
      byte_idx_q  <= 2'd0;
      asm_q       <= 24'd0;
      acc_q       <= 8'd0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready    <= rx_ready_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      cpu_hold    <= cpu_hold_d;
      load_done   <= load_done_d;
      load_error  <= load_error_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      acc_q       <= acc_d;
      idle_q      <= idle_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    rx_ready_d   = 1'b1;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_hold_d   = cpu_hold;
    load_done_d  = load_done;
    load_error_d = load_error;
    remaining_d  = remaining_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    acc_d        = acc_q;
    idle_d       = '0;

    // Inter-byte watchdog; only counts while a frame is open
    if (state_q != S_IDLE && !rx_fire_c) begin
      if (idle_q == IDLE_LAST) begin
        state_d      = S_IDLE;
        cpu_hold_d   = 1'b0;
        load_done_d  = 1'b0;
        load_error_d = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_fire_c && rx_data == HEADER) begin
          state_d      = S_COUNT;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
        end
      end
      S_COUNT: begin
        if (rx_fire_c) begin
          state_d     = S_DATA;
          remaining_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          word_idx_d  = 8'd0;
          byte_idx_d  = 2'd0;
          acc_d       = 8'd0;
        end
      end
      S_DATA: begin
        if (rx_fire_c) begin
          asm_d      = {asm_q[15:0], rx_data};
          acc_d      = acc_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {asm_q, rx_data};
            word_idx_d   = word_idx_q + 8'd1;
            remaining_d  = remaining_q - 9'd1;
            if (remaining_q == 9'd1) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rx_fire_c) begin
          state_d      = S_IDLE;
          cpu_hold_d   = 1'b0;
          load_done_d  = (rx_data == acc_q);
          load_error_d = (rx_data != acc_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum errors, 256-word load,
// timeout and mid-frame reset, with hand-computed expectations.
module tb_imem_loader;

  localparam int unsigned TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  imem_loader #(.HEADER(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Record every IMEM write, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_we"},       32'(imem_we), 32'd0);
    chk({tag, "_addr"},     32'(imem_addr), 32'd0);
    chk({tag, "_wdata"},    imem_wdata, 32'd0);
    chk({tag, "_hold"},     32'(cpu_hold), 32'd0);
    chk({tag, "_done"},     32'(load_done), 32'd0);
    chk({tag, "_error"},    32'(load_error), 32'd0);
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rx_ready_pre_edge", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rx_ready_rise", 32'(rx_ready), 32'd1);

    // Garbage in IDLE, then a gapped single-word frame
    send(8'h00); send(8'hFF); send(8'h12);
    chk("garbage_hold", 32'(cpu_hold), 32'd0);
    chk("garbage_nowrite", 32'(wa.size()), 32'd0);
    send(8'hA5);
    chk("gap_hold_rise", 32'(cpu_hold), 32'd1);
    idle(5); send(8'h01);
    idle(5); send(8'hDE);
    idle(5); send(8'hAD);
    idle(5); send(8'hBE);
    idle(5); send(8'hEF);
    idle(5); send(8'h22);
    chk("gap_done", 32'(load_done), 32'd1);
    chk("gap_error", 32'(load_error), 32'd0);
    chk("gap_hold_fall", 32'(cpu_hold), 32'd0);
    idle(2);
    chk("gap_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() >= 1) begin
      chk("gap_addr", 32'(wa[0]), 32'd0);
      chk("gap_data", wd[0], 32'hDEADBEEF);
    end

    // Nominal two-word frame at full rate
    base = wa.size();
    send(8'hA5);
    chk("nom_done_clr", 32'(load_done), 32'd0);
    chk("nom_hold", 32'(cpu_hold), 32'd1);
    send(8'h02);
    send(8'h8C); send(8'h22); send(8'h00);
    chk("nom_no_early_we", 32'(imem_we), 32'd0);
    send(8'h04);
    chk("nom_we0", 32'(imem_we), 32'd1);
    chk("nom_addr0", 32'(imem_addr), 32'd0);
    chk("nom_data0", imem_wdata, 32'h8C220004);
    send(8'h00);
    chk("nom_we_pulse", 32'(imem_we), 32'd0);
    send(8'h43); send(8'h20); send(8'h20);
    chk("nom_we1", 32'(imem_we), 32'd1);
    chk("nom_addr1", 32'(imem_addr), 32'd1);
    chk("nom_data1", imem_wdata, 32'h00432020);
    chk("nom_hold_pre_chk", 32'(cpu_hold), 32'd1);
    send(8'hE9);
    chk("nom_done", 32'(load_done), 32'd1);
    chk("nom_error", 32'(load_error), 32'd0);
    chk("nom_hold_fall", 32'(cpu_hold), 32'd0);

    // Back-to-back frame with a bad checksum
    send(8'hA5);
    chk("b2b_hold", 32'(cpu_hold), 32'd1);
    send(8'h02);
    send(8'h8C); send(8'h22); send(8'h00); send(8'h04);
    send(8'h00); send(8'h43); send(8'h20); send(8'h20);
    send(8'hE8);
    chk("badchk_error", 32'(load_error), 32'd1);
    chk("badchk_done", 32'(load_done), 32'd0);
    chk("badchk_hold", 32'(cpu_hold), 32'd0);
    idle(2);
    chk("two_frames_nwrites", 32'(wa.size() - base), 32'd4);
    if (wa.size() - base == 4) begin
      chk("badchk_addr0", 32'(wa[base+2]), 32'd0);
      chk("badchk_data0", wd[base+2], 32'h8C220004);
      chk("badchk_addr1", 32'(wa[base+3]), 32'd1);
      chk("badchk_data1", wd[base+3], 32'h00432020);
    end

    // COUNT=00 means 256 words
    base = wa.size();
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 1024; i++) send(8'h00);
    chk("full_hold_pre_chk", 32'(cpu_hold), 32'd1);
    send(8'h00);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_error", 32'(load_error), 32'd0);
    idle(2);
    chk("full_nwrites", 32'(wa.size() - base), 32'd256);
    if (wa.size() - base == 256) begin
      for (int i = 0; i < 256; i++) begin
        chk($sformatf("full_addr%0d", i), 32'(wa[base+i]), 32'(i));
      end
    end

    // Timeout after a partial word
    base = wa.size();
    send(8'hA5); send(8'h01); send(8'h8C); send(8'h22);
    idle(TIMEOUT - 1);
    chk("to_error_early", 32'(load_error), 32'd0);
    chk("to_hold_early", 32'(cpu_hold), 32'd1);
    idle(1);
    chk("to_error", 32'(load_error), 32'd1);
    chk("to_done", 32'(load_done), 32'd0);
    chk("to_hold_fall", 32'(cpu_hold), 32'd0);
    chk("to_nowrite", 32'(wa.size() - base), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    base = wa.size();
    send(8'hA5); send(8'h01); send(8'hDE); send(8'hAD);
    rx_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    chk("midrst_ready", 32'(rx_ready), 32'd1);
    chk("midrst_nowrite", 32'(wa.size() - base), 32'd0);
    send(8'hA5); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    chk("post_done", 32'(load_done), 32'd1);
    chk("post_error", 32'(load_error), 32'd0);
    idle(2);
    chk("post_nwrites", 32'(wa.size() - base), 32'd1);
    if (wa.size() - base == 1) begin
      chk("post_addr", 32'(wa[base]), 32'd0);
      chk("post_data", wd[base], 32'h11223344);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
